// File: rtl/js_pkg.sv
// -----------------------------------------------------------------------------
// js_pkg
// Shared definitions for the JS packing stage: default block geometry and the
// state encoding of the word-to-block packer.
//   JS_BLOCK_SIZE_DEF : default block length in bytes
//   JS_IN_W_DEF       : default input word width in bits
//   js_pack_st_e      : FILL (collecting words) / FULL (holding a block)
// -----------------------------------------------------------------------------
package js_pkg;

  localparam int JS_BLOCK_SIZE_DEF = 256;
  localparam int JS_IN_W_DEF       = 32;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } js_pack_st_e;

endpackage

// File: rtl/js_blk_pack.sv
// -----------------------------------------------------------------------------
// js_blk_pack
// Packs a stream of IN_W-bit words into one BLOCK_SIZE-byte block for the
// JS_XOR x_in operand. The first accepted word lands in the LSBs. Once the
// block is complete it is held on blk_data until the downstream stage takes
// it, after which the buffer is cleared and filling restarts at word 0.
//
// Parameters
//   BLOCK_SIZE : block length in bytes
//   IN_W       : input word width in bits (multiple of 8, divides BLOCK_SIZE*8)
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_data    : input word
//   in_valid   : in_data is valid
//   in_last    : current word ends the message (early flush build only)
//   in_ready   : a word is accepted this cycle when in_valid is also high
//   blk_data   : packed block, unfilled lanes read as zero
//   blk_valid  : blk_data is valid
//   blk_ready  : downstream takes the block
//   blk_bytes  : number of valid bytes in blk_data
//   blk_last   : this block closes the message
//
// Configuration
//   JS_PACK_LAST_EN : when defined, a word accepted with in_last=1 closes the
//                     block early with a partial byte count and blk_last=1.
//                     When undefined, in_last is ignored and blk_last is 0.
// -----------------------------------------------------------------------------
module js_blk_pack
  import js_pkg::*;
#(
  parameter int BLOCK_SIZE = JS_BLOCK_SIZE_DEF,
  parameter int IN_W       = JS_IN_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [IN_W-1:0]               in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [BLOCK_SIZE*8-1:0]       blk_data,
  output logic                          blk_valid,
  input  logic                          blk_ready,
  output logic [$clog2(BLOCK_SIZE):0]   blk_bytes,
  output logic                          blk_last
);

  localparam int NW = BLOCK_SIZE * 8 / IN_W;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam int BW = $clog2(BLOCK_SIZE) + 1;
  localparam int WB = IN_W / 8;
  localparam logic [KW-1:0] K_MAX = KW'(NW - 1);

  js_pack_st_e   state;
  js_pack_st_e   next_state;
  logic [KW-1:0] k;
  logic          alive;
  logic          last_q;
  logic          accept;
  logic          handshake;
  logic          early;
  logic          close_blk;
  logic [BW-1:0] bytes_at_k;

  // in_last only matters in the early-flush build; otherwise it is tied off
  // so that a stray in_last can never close a block.
`ifdef JS_PACK_LAST_EN
  assign early = in_last;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign early          = 1'b0;
`endif

  // alive keeps in_ready low throughout reset and for the gap up to the first
  // clock edge afterwards. Both handshake qualifiers come from registers only,
  // so neither ready depends combinationally on the partner's valid.
  assign in_ready   = alive && (state == FILL);
  assign blk_valid  = (state == FULL);
  assign accept     = in_valid && in_ready;
  assign handshake  = blk_valid && blk_ready;
  assign close_blk  = accept && ((k == K_MAX) || early);
  assign bytes_at_k = BW'((int'(k) + 1) * WB);

  // With early flush disabled, early is tied low, so last_q and blk_last
  // never leave zero.
  assign blk_last   = last_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: the closing word moves to FULL, the block handshake
  // returns to FILL. No word can be accepted while FULL because in_ready is 0.
  always_comb begin
    next_state = state;
    case (state)
      FILL:    if (close_blk) next_state = FULL;
      FULL:    if (blk_ready) next_state = FILL;
      default: next_state = FILL;
    endcase
  end

  // Goes high on the first edge after reset and stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  // Buffer, word index and block descriptors. The handshake clears everything
  // so a short block after a long one never carries stale upper lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_data  <= '0;
      k         <= '0;
      blk_bytes <= '0;
      last_q    <= 1'b0;
    end else if (handshake) begin
      blk_data  <= '0;
      k         <= '0;
      blk_bytes <= '0;
      last_q    <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < NW; i++) begin
        if (k == KW'(i)) begin
          blk_data[i*IN_W +: IN_W] <= in_data;
        end
      end
      if (close_blk) begin
        blk_bytes <= bytes_at_k;
        last_q    <= early;
      end else begin
        k <= k + KW'(1);
      end
    end
  end

endmodule

// File: doc/js_blk_pack.md
JS_BLK_PACK -- requirements
Module: js_blk_pack

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 256, meaning block length in bytes (matches the JS_XOR x_in/z_in width of BLOCK_SIZE*8 bits).
REQ-002 SHALL have parameter IN_W, default 32, meaning input word width in bits; IN_W SHALL be a multiple of 8 and SHALL divide BLOCK_SIZE*8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_data, input, IN_W bits: input word.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_last, input, 1 bit: the current word ends the message; qualified by in_valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-009 SHALL have port blk_data, output, BLOCK_SIZE*8 bits: the packed block, fed to JS_XOR x_in.
REQ-010 SHALL have port blk_valid, output, 1 bit: blk_data is valid.
REQ-011 SHALL have port blk_ready, input, 1 bit: the downstream stage takes the block.
REQ-012 SHALL have port blk_bytes, output, $clog2(BLOCK_SIZE)+1 bits: count of valid bytes in blk_data.
REQ-013 SHALL have port blk_last, output, 1 bit: this block closes the message.

Function
REQ-014 SHALL implement a two-state machine: FILL (collecting words) and FULL (holding a block).
REQ-015 In FILL, in_ready SHALL be 1; in FULL, in_ready SHALL be 0.
REQ-016 A word SHALL be accepted when in_valid and in_ready are both 1, and SHALL be written at word index k, bits [k*IN_W +: IN_W], with k starting at 0. The first word SHALL occupy the LSBs.
REQ-017 The word counter k SHALL run from 0 to NW-1, where NW = BLOCK_SIZE*8/IN_W.
REQ-018 Accepting word NW-1 SHALL move FILL to FULL. blk_valid SHALL rise on the next cycle, with blk_bytes = BLOCK_SIZE.
REQ-019 In FULL, blk_data, blk_bytes and blk_last SHALL hold stable while blk_ready is 0.
REQ-020 blk_valid and blk_ready both 1 SHALL complete the handshake and return the state to FULL->FILL. In the same edge, the buffer SHALL clear to zero, k SHALL go to 0 and blk_last SHALL go to 0.
REQ-021 blk_valid SHALL NOT depend combinationally on blk_ready, and in_ready SHALL NOT depend combinationally on in_valid.
REQ-022 The block SHALL NOT accept an input word in the same cycle as a block handshake. Sustained throughput SHALL be NW words per NW+1 cycles.
REQ-023 Unfilled byte lanes of blk_data SHALL read as zero.

Reset
REQ-024 While rst_n is 0, the block SHALL be in state FILL with k=0, blk_data=0, blk_valid=0, blk_bytes=0, blk_last=0 and in_ready=0.
REQ-025 After rst_n deasserts, in_ready SHALL be 1 from the first clock edge onward.
REQ-026 Reset asserted mid-fill or in FULL SHALL discard the partial or held block without emitting it.

Configuration
REQ-027 Macro JS_PACK_LAST_EN enables early flush.
- Defined: accepting a word with in_last=1 at index k SHALL move the state to FULL, with blk_bytes = (k+1)*IN_W/8 and blk_last=1; higher lanes stay zero.
- Defined: in_last=1 on word NW-1 SHALL give blk_bytes = BLOCK_SIZE and blk_last=1.
REQ-028 Without JS_PACK_LAST_EN:
- in_last SHALL be ignored;
- blk_last SHALL be constant 0;
- blk_bytes SHALL equal BLOCK_SIZE whenever blk_valid=1;
- the port list SHALL be unchanged.

Structure
REQ-029 Package js_pkg SHALL hold JS_BLOCK_SIZE_DEF (256), JS_IN_W_DEF (32) and the state enum js_pack_st_e {FILL, FULL}.
REQ-030 No sub-module; the counter, FSM and buffer SHALL all live in js_blk_pack.

Verification
REQ-031 Reset, then 64 words 0x00000001..0x00000040 back-to-back with blk_ready=1:
- blk_valid SHALL rise one cycle after word 64;
- blk_data[31:0]=0x1 and blk_data[2047:2016]=0x40;
- blk_bytes=256.
REQ-032 Full block held with blk_ready=0 for 10 cycles while in_valid=1:
- in_ready SHALL stay 0;
- blk_data SHALL be unchanged;
- on the 11th cycle blk_ready=1 SHALL complete the handshake, and the next word SHALL land at index 0.
REQ-033 JS_PACK_LAST_EN defined, 3 words 0xAABBCCDD with in_last on the 3rd:
- blk_bytes=12, blk_last=1;
- bits [2047:96]=0.
REQ-034 JS_PACK_LAST_EN not defined, same stimulus as REQ-033:
- no blk_valid until 64 words total;
- blk_last=0.
REQ-035 rst_n pulsed low after 30 words:
- blk_valid SHALL stay 0;
- a following 64-word stream SHALL produce one block with blk_data[31:0] equal to the first post-reset word.
REQ-036 Two back-to-back blocks with blk_ready=1 and random in_valid gaps:
- exactly 2 blk_valid handshakes;
- the second block SHALL carry no residue from the first.
